// File: rtl/serial_nonce_tx.sv
// Serial nonce reporter: each 32-bit nonce goes out as four 8N1 UART bytes, MSB first.
// Define SERIAL_NONCE_FIFO_EN for a 4-entry queue behind the frame in flight; default has no queue.
module serial_nonce_tx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] nonce_in,
  input  logic        nonce_valid,
  output logic        txd,
  output logic        busy,
  output logic        overflow
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);

  state_t      state;
  logic [15:0] clk_cnt;
  logic [2:0]  bit_idx;
  logic [1:0]  byte_idx;
  logic [31:0] frame;

  logic        bit_end;
  logic        frame_end;
  logic        have_q;
  logic        strobe_direct;
  logic        start_new;
  logic        push;
  logic        pop;
  logic        drop;
  logic [31:0] q_head;
  logic [31:0] start_data;
  logic [2:0]  bit_next;
  logic [4:0]  sel_first;
  logic [4:0]  sel_next;

  // nonce_valid is a one-cycle strobe with no ready: every strobe is either
  // started, queued, or dropped (setting overflow) on the edge that samples it.
  assign bit_end       = (clk_cnt == BIT_LAST);
  assign frame_end     = (state == STOP) && bit_end && (byte_idx == 2'd3);
  assign strobe_direct = nonce_valid && ((state == IDLE) || (frame_end && !have_q));
  assign pop           = frame_end && have_q;
  assign start_new     = strobe_direct || pop;
  assign start_data    = pop ? q_head : nonce_in;
  assign drop          = nonce_valid && !strobe_direct && !push;

  // Byte 0 is the MSB, so its bits live at frame[31:24]: bit index = {~byte_idx, bit_idx}.
  assign bit_next  = bit_idx + 3'd1;
  assign sel_first = {~byte_idx, 3'd0};
  assign sel_next  = {~byte_idx, bit_next};

`ifdef SERIAL_NONCE_FIFO_EN
  localparam int DEPTH = 4;

  logic [31:0] q_mem [DEPTH];
  logic [1:0]  rd_ptr;
  logic [1:0]  wr_ptr;
  logic [2:0]  q_count;

  assign have_q = (q_count != 3'd0);
  assign q_head = q_mem[rd_ptr];
  // A full queue still accepts when the head leaves on the same edge.
  assign push   = nonce_valid && !strobe_direct && ((q_count != 3'd4) || pop);

  always_ff @(posedge clk) begin
    if (push) begin
      q_mem[wr_ptr] <= nonce_in;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      q_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   q_count <= q_count + 3'd1;
        2'b01:   q_count <= q_count - 3'd1;
        default: q_count <= q_count;
      endcase
    end
  end
`else
  assign have_q = 1'b0;
  assign q_head = '0;
  assign push   = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      clk_cnt  <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      frame    <= '0;
      txd      <= 1'b1;
      busy     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (drop) overflow <= 1'b1;

      if ((state == IDLE) || bit_end) clk_cnt <= '0;
      else                            clk_cnt <= clk_cnt + 16'd1;

      case (state)
        IDLE: begin
          if (start_new) begin
            state    <= START;
            frame    <= start_data;
            byte_idx <= '0;
            txd      <= 1'b0;
            busy     <= 1'b1;
          end
        end
        START: begin
          if (bit_end) begin
            state   <= DATA;
            bit_idx <= '0;
            txd     <= frame[sel_first];
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_idx == 3'd7) begin
              state <= STOP;
              txd   <= 1'b1;
            end else begin
              bit_idx <= bit_next;
              txd     <= frame[sel_next];
            end
          end
        end
        STOP: begin
          if (bit_end) begin
            if (byte_idx != 2'd3) begin
              state    <= START;
              byte_idx <= byte_idx + 2'd1;
              txd      <= 1'b0;
            end else if (start_new) begin
              // Next nonce follows the final stop bit with no idle gap.
              state    <= START;
              frame    <= start_data;
              byte_idx <= '0;
              txd      <= 1'b0;
            end else begin
              state    <= IDLE;
              byte_idx <= '0;
              busy     <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_nonce_tx.sv
// Bench for serial_nonce_tx at CLKS_PER_BIT=4; follows SERIAL_NONCE_FIFO_EN for the queue depth.
module tb_serial_nonce_tx;

  localparam int CPB   = 4;
  localparam int FRAME = 40 * CPB;
`ifdef SERIAL_NONCE_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [31:0] nonce_in = '0;
  logic        nonce_valid = 1'b0;
  logic        txd;
  logic        busy;
  logic        overflow;

  serial_nonce_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .nonce_in    (nonce_in),
    .nonce_valid (nonce_valid),
    .txd         (txd),
    .busy        (busy),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  // Reference model: the nonce on the wire, cycles left in its frame, waiting nonces.
  logic [7:0]  exp_q[$];
  logic [31:0] pend_q[$];
  logic [31:0] m_cur = '0;
  int          m_left = 0;
  logic        m_ovf = 1'b0;

  // UART receiver sampling mid-bit.
  bit          rx_busy = 1'b0;
  int          rx_t = 0;
  logic [7:0]  rx_byte = '0;
  int          rx_count = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic m_start(input logic [31:0] d);
    m_cur  = d;
    m_left = FRAME;
    for (int i = 3; i >= 0; i--) exp_q.push_back(8'(d >> (8 * i)));
  endtask

  task automatic m_step(input logic v, input logic [31:0] d);
    if (m_left == 1) begin
      m_left = 0;
      if (pend_q.size() > 0) m_start(pend_q.pop_front());
    end else if (m_left > 1) begin
      m_left--;
    end
    if (v) begin
      if (m_left == 0)                m_start(d);
      else if (pend_q.size() < DEPTH) pend_q.push_back(d);
      else                            m_ovf = 1'b1;
    end
  endtask

  function automatic logic exp_txd();
    int el, b, w;
    if (m_left == 0) return 1'b1;
    el = FRAME - m_left;
    b  = el / CPB;
    w  = b % 10;
    if (w == 0) return 1'b0;
    if (w == 9) return 1'b1;
    return m_cur[8 * (3 - b / 10) + (w - 1)];
  endfunction

  task automatic rx_step();
    int k;
    if (!rx_busy) begin
      if (txd === 1'b0) begin
        rx_busy = 1'b1;
        rx_t    = 0;
      end
    end else begin
      rx_t++;
      if (rx_t % CPB == CPB / 2) begin
        k = rx_t / CPB;
        if (k == 0) begin
          check("rx_start_bit", txd, 0);
        end else if (k <= 8) begin
          rx_byte[k - 1] = txd;
        end else begin
          check("rx_stop_bit", txd, 1);
          check("rx_byte_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) check("rx_byte", rx_byte, exp_q.pop_front());
          rx_count++;
          rx_busy = 1'b0;
        end
      end
    end
  endtask

  task automatic tick(input logic v, input logic [31:0] d);
    nonce_valid = v;
    nonce_in    = v ? d : $urandom();
    @(posedge clk);
    m_step(v, d);
    #1;
    nonce_valid = 1'b0;
    check("txd", txd, exp_txd());
    check("busy", busy, m_left != 0);
    check("overflow", overflow, m_ovf);
    rx_step();
  endtask

  task automatic do_reset();
    reset_n     = 1'b0;
    nonce_valid = 1'b0;
    #1;
    check("rst_txd", txd, 1);
    check("rst_busy", busy, 0);
    check("rst_overflow", overflow, 0);
    m_left = 0;
    m_ovf  = 1'b0;
    pend_q.delete();
    exp_q.delete();
    rx_busy  = 1'b0;
    rx_count = 0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic run_to_idle(input int bound, output int n);
    n = 0;
    while (busy !== 1'b0 && n < bound) begin
      tick(1'b0, '0);
      n++;
    end
    check("idle_reached", busy, 0);
  endtask

  initial begin
    int n;
    int base;

    // Single nonce: latency, byte order, frame length.
    do_reset();
    tick(1'b1, 32'h1afda099);
    check("s1_latency_txd", txd, 0);
    check("s1_busy_high", busy, 1);
    run_to_idle(400, n);
    check("s1_busy_len", n, 160);
    check("s1_rx_count", rx_count, 4);
    check("s1_exp_empty", exp_q.size(), 0);
    check("s1_overflow", overflow, 0);

    // Second strobe while the first frame is in flight.
    do_reset();
    tick(1'b1, 32'h30d9db77);
    repeat (49) tick(1'b0, '0);
    tick(1'b1, 32'h00000001);
    repeat (110) tick(1'b0, '0);
    check("s2_gap_txd", txd, (DEPTH > 0) ? 0 : 1);
    check("s2_gap_busy", busy, (DEPTH > 0) ? 1 : 0);
    run_to_idle(400, n);
    check("s2_rx_count", rx_count, (DEPTH > 0) ? 8 : 4);
    check("s2_overflow", overflow, (DEPTH > 0) ? 0 : 1);
    check("s2_exp_empty", exp_q.size(), 0);

    // Six back-to-back strobes: storage runs out.
    do_reset();
    for (int i = 0; i < 6; i++) tick(1'b1, $urandom());
    run_to_idle(2000, n);
    check("s3_rx_count", rx_count, (DEPTH > 0) ? 20 : 4);
    check("s3_overflow", overflow, 1);
    base = rx_count;
    tick(1'b1, $urandom());
    run_to_idle(400, n);
    check("s3_sticky_overflow", overflow, 1);
    check("s3_rx_after", rx_count, base + 4);
    check("s3_exp_empty", exp_q.size(), 0);

    // Strobe on the last cycle of the final stop bit.
    do_reset();
    tick(1'b1, $urandom());
    repeat (159) tick(1'b0, '0);
    tick(1'b1, 32'hc0ffee11);
    check("s4_restart_txd", txd, 0);
    check("s4_restart_busy", busy, 1);
    check("s4_overflow", overflow, 0);
    run_to_idle(400, n);
    check("s4_rx_count", rx_count, 8);
    check("s4_exp_empty", exp_q.size(), 0);

    // Reset in the middle of byte 2 while txd is low.
    do_reset();
    tick(1'b1, 32'h00000000);
    repeat (95) tick(1'b0, '0);
    check("s5_pre_reset_txd", txd, 0);
    do_reset();
    tick(1'b1, $urandom());
    run_to_idle(400, n);
    check("s5_rx_count", rx_count, 4);
    check("s5_exp_empty", exp_q.size(), 0);

    // Random strobe traffic.
    do_reset();
    repeat (3000) tick($urandom_range(0, 99) < 4, $urandom());
    run_to_idle(1500, n);
    check("s6_exp_empty", exp_q.size(), 0);
    check("s6_overflow", overflow, m_ovf);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
